// File: rtl/disp_scan_ctrl.sv
// 4-digit multiplexed display scanner.
// A prescaler paces the digit index; new 16-bit values are double-buffered
// through a shadow register and become visible only at a frame boundary,
// so a frame never mixes old and new digits.
module disp_scan_ctrl #(
  parameter int TICK_DIV = 400000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_lz_en,
  input  logic        i_load_valid,
  input  logic [15:0] i_load_data,
  output logic        o_load_ready,
  output logic [1:0]  o_control,
  output logic [3:0]  o_digit_out,
  output logic [7:0]  o_anode,
  output logic        o_frame_tick
);

  localparam int             PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]  r_presc;
  logic [1:0]     r_control;
  logic           r_frame_tick;
  logic [15:0]    r_shadow;
  logic [15:0]    r_active;
  logic           r_pending;

  logic           w_tick;
  logic           w_wrap;
  logic           w_accept;
  logic [3:0][3:0] w_nib;
  logic [3:0]     w_lit_mask;
  logic           w_lit;

  assign w_tick   = (r_presc == LAST);
  assign w_wrap   = w_tick && (r_control == 2'd3);
  assign w_accept = i_load_valid && !r_pending;

  // Prescaler and digit index; index advances on the prescaler's last count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc   <= '0;
      r_control <= 2'd0;
    end else if (w_tick) begin
      r_presc   <= '0;
      r_control <= r_control + 2'd1;
    end else begin
      r_presc   <= r_presc + PW'(1);
    end
  end

  // Frame tick: registered, high in the first index-0 cycle after a wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_frame_tick <= 1'b0;
    else         r_frame_tick <= w_wrap;
  end

  // Load handshake and frame-aligned commit. Commit needs pending=1 and
  // accept needs pending=0, so the two never fire on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else if (w_wrap && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_shadow  <= i_load_data;
      r_pending <= 1'b1;
    end
  end

  // Digit k is lit unless suppression is on and nibbles k..3 are all zero.
  assign w_lit_mask[0] = 1'b1;
  for (genvar k = 1; k < 4; k++) begin : g_lz
    assign w_lit_mask[k] = !i_lz_en || (|r_active[15:4*k]);
  end

  assign w_nib = r_active;
  assign w_lit = i_enable && w_lit_mask[r_control];

  // Outputs: digit select, anode drive (active low), handshake.
  always_comb begin
    o_anode = 8'hFF;
    if (w_lit) o_anode[3:0] = ~(4'b0001 << r_control);
  end

  assign o_digit_out  = w_nib[r_control];
  assign o_control    = r_control;
  assign o_load_ready = !r_pending;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl with a cycle-indexed reference model
// and a scoreboard queue drained by an independent monitor.
module tb_disp_scan_ctrl;

  localparam int TD = 4;
  localparam int FR = 4 * TD;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_lz_en, i_load_valid;
  logic [15:0] i_load_data;
  logic        o_load_ready, o_frame_tick;
  logic [1:0]  o_control;
  logic [3:0]  o_digit_out;
  logic [7:0]  o_anode;

  disp_scan_ctrl #(.TICK_DIV(TD)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_lz_en(i_lz_en),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data),
    .o_load_ready(o_load_ready), .o_control(o_control),
    .o_digit_out(o_digit_out), .o_anode(o_anode), .o_frame_tick(o_frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lr;
    logic [1:0] ctl;
    logic [3:0] dig;
    logic [7:0] an;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: cycle count since reset plus the buffered values.
  int          m_n;
  logic [15:0] m_shadow, m_act;
  logic        m_pend;
  logic        g_en, g_lz;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: outputs are continuous, so every cycle presents one sample.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("load_ready", int'(o_load_ready), int'(e.lr));
      check("control",    int'(o_control),    int'(e.ctl));
      check("digit_out",  int'(o_digit_out),  int'(e.dig));
      check("anode",      int'(o_anode),      int'(e.an));
      check("frame_tick", int'(o_frame_tick), int'(e.ft));
    end
  end

  task automatic step(input logic rst, input logic vld, input logic [15:0] d);
    exp_t e;
    int   ctl;
    logic lit;
    i_reset = rst; i_enable = g_en; i_lz_en = g_lz;
    i_load_valid = vld; i_load_data = d;
    ctl   = (m_n / TD) % 4;
    lit   = g_en && (!g_lz || ctl == 0 || (m_act >> (4 * ctl)) != 16'h0);
    e.lr  = !m_pend;
    e.ctl = 2'(ctl);
    e.dig = m_act[4*ctl +: 4];
    e.an  = lit ? (8'hFF & ~(8'h01 << ctl)) : 8'hFF;
    e.ft  = (m_n > 0) && (m_n % FR == 0);
    q.push_back(e);
    @(posedge clk); #1;
    if (rst) begin
      m_n = 0; m_shadow = 0; m_act = 0; m_pend = 0;
    end else begin
      if ((m_n % FR == FR - 1) && m_pend) begin
        m_act = m_shadow; m_pend = 0;
      end else if (vld && !m_pend) begin
        m_shadow = d; m_pend = 1;
      end
      m_n++;
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < FR && (m_n % FR) != phase; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    g_en = 1; g_lz = 0;
    i_reset = 1; i_enable = 1; i_lz_en = 0; i_load_valid = 0; i_load_data = 0;
    @(posedge clk); #1;
    m_n = 0; m_shadow = 0; m_act = 0; m_pend = 0;

    step(1'b1, 1'b0, 16'h0);              // held reset: reset-state outputs
    run(40);                               // free run, ticks every 16 cycles

    run_until(5);                          // CONTROL=1
    step(1'b0, 1'b1, 16'h1234);
    run(24);

    step(1'b0, 1'b1, 16'hAAAA);            // back-to-back, second ignored
    step(1'b0, 1'b1, 16'h5555);
    run(24);

    run_until(FR - 1);                     // accept on the 3->0 edge
    step(1'b0, 1'b1, 16'hBEEF);
    run(2 * FR);

    g_lz = 1;
    step(1'b0, 1'b1, 16'h0070);
    run(2 * FR + 4);
    g_en = 0; run(FR);
    g_en = 1; g_lz = 0;

    run_until(1);                          // pending with CONTROL=2, then reset
    step(1'b0, 1'b1, 16'h9999);
    run_until(9);
    step(1'b1, 1'b0, 16'h0);
    run(FR + 2);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = d & (16'hFFFF >> (4 * $urandom_range(1, 3)));
      if ($urandom_range(0, 49) == 0) g_en = ~g_en;
      if ($urandom_range(0, 29) == 0) g_lz = ~g_lz;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, d);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
